sort4_group_loader: RTL and testbench
=====================================

Name: sort4_group_loader

Overview:
- Upstream feeder for the 4-input max/min sorting stage.
- Accepts a scalar sample stream with a valid/ready handshake and packs samples into 4-element groups.
- Pads short final groups with a sentinel and presents each group as a registered 4-lane vector with valid/ready.
- Its out_data lanes connect directly to the sorter's indata[0:3].

Parameters:
- width, 8, bit width of each sample/lane
- PAD_VAL, {width{1'b1}}, value written into unfilled lanes. All-ones by default, so padding sorts to the top lanes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of clk)
- in_data  input  width  incoming sample
- in_valid  input  1  in_data is valid
- in_last  input  1  sample closes the current group (flush); qualified by in_valid
- in_ready  output  1  loader accepts a sample this cycle
- out_data  output  width x [0:3]  assembled group, lane 0 = first sample received
- out_count  output  3  number of real samples in the group, 1..4
- out_last  output  1  group was closed by in_last
- out_valid  output  1  out_data/out_count/out_last valid
- out_ready  input  1  downstream accepts the group

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Storage:
  - Assembly register: 4 lanes, 2-bit fill index cnt, last flag.
  - Output register: 4 lanes, count, last, out_valid.
- The output slot is free this cycle when !out_valid || out_ready.
- States:
  - FILL: collecting samples. in_ready = 1.
  - HELD: assembly holds a completed group but the output slot was busy. in_ready = 0.
  - in_ready is a function of state only. There is no combinational path from out_ready or in_valid to in_ready.
- FILL, on input transfer:
  - Write in_data to lane cnt.
  - The group completes if cnt == 3 or in_last == 1.
  - Not completing: cnt <= cnt + 1.
  - Completing with the slot free: load the output register directly on this edge, including the incoming sample. Lanes above cnt get PAD_VAL; out_count = cnt + 1; out_last = in_last; out_valid <= 1. Then cnt <= 0 and assembly lanes are reset to PAD_VAL; stay in FILL.
  - Completing with the slot busy: store the sample and the count/last, then go to HELD.
- HELD:
  - When the slot is free, move the assembly to the output register (out_valid <= 1), set cnt <= 0, and go to FILL.
  - Back-to-back: the transfer may happen on the same edge as the downstream accept of the previous group.
- Output register:
  - If out_valid && out_ready and nothing new is loaded, out_valid <= 0.
  - While out_valid && !out_ready, all output fields are held stable.
- Latency: the sample that completes a group appears on out_data exactly 1 cycle after its input transfer when the slot is free. A full group costs 4 input transfers.
- Throughput: 1 sample/cycle sustained while out_ready = 1.
- Lane ordering: lane i = i-th sample of the group. PAD_VAL only in lanes >= out_count.
- in_last:
  - With cnt == 3, it simply marks out_last.
  - A lone in_last sample at cnt == 0 yields out_count = 1, lanes 1..3 = PAD_VAL.
  - There are no empty groups: without a valid sample, no flush occurs.
- Reset (rst == 0 at a clock edge):
  - state <= FILL, cnt <= 0, assembly lanes <= PAD_VAL.
  - out_valid <= 0, out_data lanes <= 0, out_count <= 0, out_last <= 0.
  - in_ready = 0 while rst == 0; it rises to 1 in the first cycle after release.
  - Reset mid-group or in HELD discards the partial/held group with no output.
- in_data/in_last are don't-care when in_valid = 0.

Test Plan:
- Reset, then stream 10,20,30,40 with in_valid = 1 and out_ready = 1 -> one cycle after the 4th transfer: out_valid = 1, out_data = {10,20,30,40}, out_count = 4, out_last = 0; in_ready stays 1 throughout.
- Send 7,3 (in_last on 3), width = 8 -> out_data = {7,3,255,255}, out_count = 2, out_last = 1; next group starts at lane 0.
- Single sample 5 with in_last -> out_data = {5,255,255,255}, out_count = 1.
- out_ready = 0; stream 8 samples 1..8 -> first group {1,2,3,4} held stable. After sample 8 the loader enters HELD and in_ready = 0. Raise out_ready -> {1,2,3,4} accepted, then {5,6,7,8} presented the next cycle; in_ready returns to 1.
- Continuous 12 samples with out_ready = 1 -> 3 groups, out_valid pulses one cycle each every 4 cycles, no dropped or duplicated samples.
- Assert rst = 0 after 2 samples of a group and during HELD -> out_valid = 0, all out_data = 0 next cycle. After release, 4 new samples 9,9,9,9 yield exactly {9,9,9,9} with no residue from before reset.

Source files
------------

// File: rtl/sort4_group_loader_if.sv
// sort4_group_loader_if
//   Bundles the sample-side and group-side handshakes of the group loader.
//   Ports (signals):
//     in_data   sample toward the loader
//     in_valid  in_data is valid
//     in_last   sample closes the current group
//     in_ready  loader accepts a sample this cycle
//     out_data  4-lane assembled group, lane 0 = first sample
//     out_count number of real samples in the group (1..4)
//     out_last  group was closed by in_last
//     out_valid group fields are valid
//     out_ready downstream accepts the group
//   Modports:
//     master  the side that feeds samples and consumes groups
//     slave   the loader itself
interface sort4_group_loader_if #(
    parameter int width = 8
);
    logic [width-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [width-1:0] out_data [0:3];
    logic [2:0]       out_count;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_last, out_valid
    );
endinterface

// File: rtl/sort4_group_loader.sv
// sort4_group_loader
//   Packs a scalar sample stream into 4-lane groups for the 4-input sorter.
//   Short groups (closed by in_last) are padded with PAD_VAL. Each group is
//   presented from a registered output slot with valid/ready.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-low reset
//     bus  slave side of sort4_group_loader_if (sample in, group out)
module sort4_group_loader #(
    parameter int               width   = 8,
    parameter logic [width-1:0] PAD_VAL = {width{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    sort4_group_loader_if.slave   bus
);

    typedef enum logic {
        FILL,
        HELD
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [width-1:0] asm_lane [0:3];
    logic [1:0]       cnt;
    logic             asm_last;

    logic [width-1:0] out_lane [0:3];
    logic [2:0]       out_cnt_q;
    logic             out_last_q;
    logic             out_valid_q;

    logic             in_ready_int;
    logic             in_fire;
    logic             slot_free;
    logic             complete;
    logic             load_direct;
    logic             go_held;
    logic             load_held;

    // in_ready depends only on the state register, gated low while reset is
    // held so nothing is accepted during reset.
    assign in_ready_int = rst && (state == FILL);

    // Next-state and control decode. A group completes on its fourth sample
    // or on an in_last sample; if the output slot is free on that edge the
    // group bypasses the assembly register and lands straight in the output.
    // HELD is only entered when the slot was busy at completion time.
    always_comb begin
        state_next  = state;
        in_fire     = 1'b0;
        slot_free   = 1'b0;
        complete    = 1'b0;
        load_direct = 1'b0;
        go_held     = 1'b0;
        load_held   = 1'b0;

        slot_free = !out_valid_q || bus.out_ready;
        in_fire   = bus.in_valid && in_ready_int;
        complete  = in_fire && ((cnt == 2'd3) || bus.in_last);

        case (state)
            FILL: begin
                load_direct = complete && slot_free;
                go_held     = complete && !slot_free;
                if (go_held) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (slot_free) begin
                    load_held  = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // State, assembly and output registers. While HELD, cnt keeps the lane
    // index of the final sample, so the held group's count is cnt + 1 and
    // its unfilled lanes already carry PAD_VAL from the last clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FILL;
            cnt         <= 2'd0;
            asm_last    <= 1'b0;
            out_cnt_q   <= 3'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                asm_lane[i] <= PAD_VAL;
                out_lane[i] <= '0;
            end
        end else begin
            state <= state_next;

            if (load_direct) begin
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) == cnt) begin
                        out_lane[i] <= bus.in_data;
                    end else if (2'(i) < cnt) begin
                        out_lane[i] <= asm_lane[i];
                    end else begin
                        out_lane[i] <= PAD_VAL;
                    end
                    asm_lane[i] <= PAD_VAL;
                end
                out_cnt_q  <= {1'b0, cnt} + 3'd1;
                out_last_q <= bus.in_last;
                asm_last   <= 1'b0;
                cnt        <= 2'd0;
            end else if (in_fire) begin
                asm_lane[cnt] <= bus.in_data;
                if (go_held) begin
                    asm_last <= bus.in_last;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end else if (load_held) begin
                for (int i = 0; i < 4; i++) begin
                    out_lane[i] <= asm_lane[i];
                    asm_lane[i] <= PAD_VAL;
                end
                out_cnt_q  <= {1'b0, cnt} + 3'd1;
                out_last_q <= asm_last;
                asm_last   <= 1'b0;
                cnt        <= 2'd0;
            end

            // A new load wins over the downstream accept of the previous
            // group, which gives back-to-back groups with no bubble.
            if (load_direct || load_held) begin
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_data  = out_lane;
    assign bus.out_count = out_cnt_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sort4_group_loader.sv
// tb_sort4_group_loader
//   Scoreboard bench for sort4_group_loader. A queue-based reference model
//   groups accepted samples and pushes expected groups; a monitor compares
//   every presented group against the queue head.
//   Ports: none (top-level bench).
module tb_sort4_group_loader;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] PAD = {WIDTH{1'b1}};

    typedef struct packed {
        logic [3:0][WIDTH-1:0] lanes;
        logic [2:0]            count;
        logic                  last;
    } group_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    group_t           exp_q [$];
    logic [WIDTH-1:0] pending [$];

    int   compared     = 0;
    int   mismatched   = 0;
    int   valid_cycles = 0;

    logic ready_cmd  = 1'b0;
    logic rand_mode  = 1'b0;
    logic rand_ready = 1'b0;

    sort4_group_loader_if #(.width(WIDTH)) bus ();

    sort4_group_loader #(
        .width   (WIDTH),
        .PAD_VAL (PAD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Downstream ready is either a directed level or a random coin flip.
    assign bus.out_ready = rand_mode ? rand_ready : ready_cmd;

    // Re-roll the random ready just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rand_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference model: collect accepted samples, emit a padded group once
    // four are gathered or a sample carries last.
    task automatic modelAccept(input logic [WIDTH-1:0] d, input logic last);
        group_t g;
        pending.push_back(d);
        if (pending.size() == 4 || last) begin
            for (int i = 0; i < 4; i++) begin
                g.lanes[i] = (i < pending.size()) ? pending[i] : PAD;
            end
            g.count = 3'(pending.size());
            g.last  = last;
            exp_q.push_back(g);
            pending.delete();
        end
    endtask

    // Offer one sample; returns just after the edge where it was accepted,
    // leaving in_valid high so consecutive calls stream at full rate.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic last,
                                 input bit must_accept);
        int waited = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(negedge clk);
        if (must_accept) begin
            checkOutput("in_ready_no_stall", 32'(bus.in_ready), 32'd1);
        end
        while (!bus.in_ready) begin
            waited++;
            if (waited > 200) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL in_ready_timeout: actual=0 expected=1");
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        modelAccept(d, last);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset discards whatever is partially assembled, held or presented.
    task automatic doReset();
        ready_cmd    = 1'b0;
        rand_mode    = 1'b0;
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        exp_q.delete();
        pending.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", {bus.out_data[3], bus.out_data[2],
                                     bus.out_data[1], bus.out_data[0]}, 32'd0);
        checkOutput("rst_out_count", 32'(bus.out_count), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: every cycle a group is presented it must match the queue
    // head (this also covers stability while stalled); pop on acceptance.
    initial begin
        group_t g;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_group: actual=%0h expected=none",
                             {bus.out_data[3], bus.out_data[2], bus.out_data[1], bus.out_data[0]});
                end else begin
                    g = exp_q[0];
                    checkOutput("group_data", {bus.out_data[3], bus.out_data[2],
                                               bus.out_data[1], bus.out_data[0]}, 32'(g.lanes));
                    checkOutput("group_count", 32'(bus.out_count), 32'(g.count));
                    checkOutput("group_last", 32'(bus.out_last), 32'(g.last));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Directed scenarios followed by a randomized soak and a drain.
    initial begin
        int snap;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        doReset();
        @(negedge clk);
        checkOutput("in_ready_after_release", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        ready_cmd = 1'b1;
        applyStimulus(8'd10, 1'b0, 1'b1);
        applyStimulus(8'd20, 1'b0, 1'b1);
        applyStimulus(8'd30, 1'b0, 1'b1);
        applyStimulus(8'd40, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("latency_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("latency_lane3", 32'(bus.out_data[3]), 32'd40);
        @(posedge clk);
        #1;

        applyStimulus(8'd7, 1'b0, 1'b1);
        applyStimulus(8'd3, 1'b1, 1'b1);
        applyStimulus(8'd5, 1'b1, 1'b1);
        idle(3);

        ready_cmd = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(i), 1'b0, 1'b1);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("held_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("held_first_lane0", 32'(bus.out_data[0]), 32'd1);
        @(posedge clk);
        #1;
        ready_cmd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("after_held_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("after_held_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("after_held_lane0", 32'(bus.out_data[0]), 32'd5);
        @(posedge clk);
        #1;

        snap = valid_cycles;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'(100 + i), 1'b0, 1'b1);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("stream_valid_cycles", 32'(valid_cycles - snap), 32'd3);
        @(posedge clk);
        #1;

        applyStimulus(8'd11, 1'b0, 1'b1);
        applyStimulus(8'd12, 1'b0, 1'b1);
        doReset();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(20 + i), 1'b0, 1'b0);
        end
        bus.in_valid = 1'b0;
        doReset();
        ready_cmd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'd9, 1'b0, 1'b1);
        end
        idle(3);

        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end
            applyStimulus(WIDTH'($urandom), ($urandom_range(0, 4) == 0) || (n == 299), 1'b0);
        end
        bus.in_valid = 1'b0;
        rand_mode    = 1'b0;
        ready_cmd    = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        @(negedge clk);
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
